restoring_div_4bit: RTL and testbench
=====================================

// Module: restoring_div_4bit
// PURPOSE
//  Sequential 4-bit unsigned restoring divider. Drives one add_sub_4bit instance in subtract mode (mode=1).
//  Produces one quotient bit per clock.
//  Sits upstream of add_sub_4bit: it feeds A/B/mode and consumes S/Cout.
//  Used by the datapath wherever a 4-bit quotient/remainder is needed.
// PARAMETERS
//  WIDTH  4  operand width; fixed by the add_sub_4bit datapath; any other value is an elaboration error
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      request; sampled only when busy=0
//  dividend     in   WIDTH  unsigned, captured on accepted start
//  divisor      in   WIDTH  unsigned, captured on accepted start
//  busy         out  1      high while a division is in progress
//  done         out  1      one-cycle pulse; results valid from this cycle
//  quotient     out  WIDTH  result, held until next accepted start
//  remainder    out  WIDTH  result, held until next accepted start
//  div_by_zero  out  1      set with done when divisor==0; held like results
// BEHAVIOUR
//  - Clock/reset: one clock (clk); rst synchronous, active-high, overrides everything.
//  - Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, step count=0.
//  - States: IDLE, RUN, DONE.
//  - IDLE/DONE + start:
//    - divisor!=0: capture operands, R=0, Q=dividend, cnt=WIDTH-1, go to RUN, busy=1.
//    - divisor==0: go to DONE next cycle; quotient=4'hF, remainder=dividend, div_by_zero=1.
//  - RUN, each cycle:
//    - T={R[W-2:0],Q[W-1]}; drive add_sub A=T, B=D, mode=1.
//    - Cout=1 (T>=D): R<=S, Q<={Q[W-2:0],1}.
//    - Cout=0: R<=T (restore), Q<={Q[W-2:0],0}.
//    - cnt==0: go to DONE; else cnt<=cnt-1.
//  - Width invariant: R<D before every shift, and the shifted-in prefix is <2^i at step i.
//    Therefore T<=15 always and the 4-bit subtract with Cout as no-borrow flag is exact.
//    No 5th bit is required.
//  - DONE: done=1 for exactly this one cycle, busy=0. Without start, go to IDLE.
//    With start: start back-to-back; done still pulses.
//  - Latency: accept edge to done=1 is WIDTH+1 cycles (5); divide-by-zero is 1 cycle.
//  - start while busy=1: ignored; no queueing, operands not re-sampled.
//  - quotient/remainder/div_by_zero: updated only on the RUN->DONE or zero-divisor transition.
//    Stable otherwise, including across IDLE.
//  - rst mid-RUN: abort immediately; all outputs return to reset values; no done pulse.
//  - add_sub_4bit inputs are driven in IDLE/DONE too, but their result is ignored there.
// STRUCTURE
//  - Shared package/header:
//    - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
//    - DBZ_QUOTIENT=4'hF.
//  - One sub-module: add_sub_4bit (existing, combinational), a single instance.
//    The divider must not contain its own subtractor.
//  - Local logic: state register, 2-bit step counter, R/Q/D registers, output registers.
// TESTING
//  - 13/3: start 1 cycle -> done at accept+5, quotient=4, remainder=1, div_by_zero=0.
//  - 15/1 -> quotient=15, remainder=0.
//    3/12 -> quotient=0, remainder=3.
//    12/12 -> quotient=1, remainder=0.
//  - 7/0 -> done the next cycle; quotient=15, remainder=7, div_by_zero=1; busy never high.
//  - Pulse start again at RUN cycle 2 with 9/2 -> ignored; first result 13/3 unchanged.
//    Then start 9/2 on the DONE cycle -> back-to-back, quotient=4, remainder=1.
//  - Assert rst at RUN cycle 3 -> next edge: busy=0, done=0, all outputs 0, no done pulse.
//    Then 10/3 -> quotient=3, remainder=1.
//  - Exhaustive sweep of all 256 dividend/divisor pairs against a / and % model.
//    Check latency, done width and result hold on every pair.

Source files
------------

// File: rtl/restoring_div_4bit_pkg.sv
// Shared definitions for the 4-bit restoring divider: operand width, FSM states and
// the quotient value reported on divide-by-zero.
package restoring_div_4bit_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] DBZ_QUOTIENT = 4'hF;

endpackage

// File: rtl/restoring_div_4bit_if.sv
// Request/result bundle of the divider: the master issues start with operands,
// the slave (divider) returns busy/done and the held results.
interface restoring_div_4bit_if;
    import restoring_div_4bit_pkg::*;

    logic              start;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/restoring_div_4bit_add_sub.sv
// Combinational 4-bit adder/subtractor: mode=0 gives a+b, mode=1 gives a-b with
// cout acting as the no-borrow flag (cout=1 means a>=b).
module add_sub_4bit
    import restoring_div_4bit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              mode,
    output logic [DATA_W-1:0] s,
    output logic              cout
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;

    assign b_eff     = b ^ {DATA_W{mode}};
    assign sum       = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, mode};
    assign {cout, s} = sum;

endmodule

// File: rtl/restoring_div_4bit.sv
// Sequential 4-bit unsigned restoring divider producing one quotient bit per clock,
// using a single external add_sub_4bit in subtract mode as its only subtractor.
module restoring_div_4bit
    import restoring_div_4bit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    restoring_div_4bit_if.slave  bus
);

    if (WIDTH != DATA_W) begin : g_width_check
        $error("restoring_div_4bit: WIDTH must be 4 to match add_sub_4bit");
    end

    state_t           state, state_nxt;
    logic [1:0]       cnt, cnt_nxt;
    // Partial remainder before a shift is below 2^(WIDTH-1), so its top bit is never stored.
    logic [WIDTH-2:0] r;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic [WIDTH-1:0] d, d_nxt;
    logic [WIDTH-1:0] quo, quo_nxt;
    logic [WIDTH-1:0] rem, rem_nxt;
    logic             dbz, dbz_nxt;

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] s;
    logic             cout;

    assign t = {r, q[WIDTH-1]};

    add_sub_4bit u_add_sub (
        .a    (t),
        .b    (d),
        .mode (1'b1),
        .s    (s),
        .cout (cout)
    );

    // NOTE: every next-value gets a hold default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        r_nxt     = {1'b0, r};
        q_nxt     = q;
        d_nxt     = d;
        quo_nxt   = quo;
        rem_nxt   = rem;
        dbz_nxt   = dbz;

        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        d_nxt     = bus.divisor;
                        r_nxt     = '0;
                        q_nxt     = bus.dividend;
                        cnt_nxt   = 2'(WIDTH - 1);
                        state_nxt = S_RUN;
                    end else begin
                        quo_nxt   = DBZ_QUOTIENT;
                        rem_nxt   = bus.dividend;
                        dbz_nxt   = 1'b1;
                        state_nxt = S_DONE;
                    end
                end else if (state == S_DONE) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                // cout=1 means T>=D: keep the difference, otherwise restore T.
                r_nxt = cout ? s : t;
                q_nxt = {q[WIDTH-2:0], cout};
                if (cnt == 2'd0) begin
                    quo_nxt   = q_nxt;
                    rem_nxt   = r_nxt;
                    dbz_nxt   = 1'b0;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            r     <= '0;
            q     <= '0;
            d     <= '0;
            quo   <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            r     <= r_nxt[WIDTH-2:0];
            q     <= q_nxt;
            d     <= d_nxt;
            quo   <= quo_nxt;
            rem   <= rem_nxt;
            dbz   <= dbz_nxt;
        end
    end

    assign bus.busy        = (state == S_RUN);
    assign bus.done        = (state == S_DONE);
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_restoring_div_4bit.sv
// Self-checking bench for restoring_div_4bit: directed cases plus a randomized-gap
// sweep of all operand pairs, checked every cycle against an arithmetic model.
module tb_restoring_div_4bit;
    import restoring_div_4bit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    restoring_div_4bit_if bus ();

    restoring_div_4bit #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         due;
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
    } exp_t;

    exp_t       pend[$];
    int         cyc       = 0;
    int         idle_from = 0;
    int         n_checks  = 0;
    int         n_pass    = 0;
    logic [3:0] held_q    = '0;
    logic [3:0] held_r    = '0;
    logic       held_dbz  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Compare process: after every rising edge, outputs must match the model.
    initial begin
        logic rst_s;
        forever begin
            @(posedge clk);
            cyc++;
            rst_s = rst;
            #1;
            if (rst_s) begin
                pend.delete();
                idle_from = cyc;
                held_q    = '0;
                held_r    = '0;
                held_dbz  = 1'b0;
                check("rst_busy", bus.busy, 0);
                check("rst_done", bus.done, 0);
                check("rst_quotient", bus.quotient, 0);
                check("rst_remainder", bus.remainder, 0);
                check("rst_dbz", bus.div_by_zero, 0);
            end else begin
                check("busy", bus.busy, (cyc < idle_from) ? 1 : 0);
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    check("done_pulse", bus.done, 1);
                    check("quotient", bus.quotient, pend[0].q);
                    check("remainder", bus.remainder, pend[0].r);
                    check("div_by_zero", bus.div_by_zero, pend[0].dbz);
                    held_q   = pend[0].q;
                    held_r   = pend[0].r;
                    held_dbz = pend[0].dbz;
                    void'(pend.pop_front());
                end else begin
                    check("done_idle", bus.done, 0);
                    check("hold_quotient", bus.quotient, held_q);
                    check("hold_remainder", bus.remainder, held_r);
                    check("hold_dbz", bus.div_by_zero, held_dbz);
                end
            end
        end
    end

    // Called at a falling edge: presents a one-cycle start and records it in the model
    // if the divider is free; returns at the next falling edge with garbage operands.
    task automatic drive_start(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (!rst && cyc >= idle_from) begin
            if (b == 4'd0) begin
                e = '{due: cyc + 1, q: 4'hF, r: a, dbz: 1'b1};
                idle_from = cyc + 1;
            end else begin
                e = '{due: cyc + 5, q: a / b, r: a % b, dbz: 1'b0};
                idle_from = cyc + 5;
            end
            pend.push_back(e);
        end
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 4'($urandom);
        bus.divisor  = 4'($urandom);
    endtask

    task automatic wait_done(input int t0, output int lat);
        int n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) check("done_timeout", 0, 1);
        lat = cyc - t0;
    endtask

    task automatic directed(input string name, input logic [3:0] a, input logic [3:0] b,
                            input int lat_exp, input int q_exp, input int r_exp,
                            input int dbz_exp);
        int t0, lat;
        t0 = cyc;
        drive_start(a, b);
        wait_done(t0, lat);
        check({name, "_latency"}, lat, lat_exp);
        check({name, "_q"}, bus.quotient, q_exp);
        check({name, "_r"}, bus.remainder, r_exp);
        check({name, "_dbz"}, bus.div_by_zero, dbz_exp);
        @(negedge clk);
    endtask

    initial begin
        int t0, lat;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        directed("d13_3", 4'd13, 4'd3, 5, 4, 1, 0);
        directed("d15_1", 4'd15, 4'd1, 5, 15, 0, 0);
        directed("d3_12", 4'd3, 4'd12, 5, 0, 3, 0);
        directed("d12_12", 4'd12, 4'd12, 5, 1, 0, 0);
        directed("d7_0", 4'd7, 4'd0, 1, 15, 7, 1);

        // Start during RUN is ignored, then a back-to-back start on the DONE cycle.
        t0 = cyc;
        drive_start(4'd13, 4'd3);
        @(negedge clk);
        drive_start(4'd9, 4'd2);
        wait_done(t0, lat);
        check("ign_latency", lat, 5);
        check("ign_q", bus.quotient, 4);
        check("ign_r", bus.remainder, 1);
        t0 = cyc;
        drive_start(4'd9, 4'd2);
        wait_done(t0, lat);
        check("b2b_latency", lat, 5);
        check("b2b_q", bus.quotient, 4);
        check("b2b_r", bus.remainder, 1);
        @(negedge clk);

        // Reset in the third RUN cycle aborts without a done pulse.
        drive_start(4'd13, 4'd3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_q", bus.quotient, 0);
        check("abort_r", bus.remainder, 0);
        check("abort_dbz", bus.div_by_zero, 0);
        rst = 1'b0;
        directed("d10_3", 4'd10, 4'd3, 5, 3, 1, 0);

        // All operand pairs with random idle gaps and random ignored starts.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                t0 = cyc;
                drive_start(4'(a), 4'(b));
                if (b != 0 && $urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    drive_start(4'($urandom), 4'($urandom));
                end
                wait_done(t0, lat);
                check("sweep_latency", lat, (b == 0) ? 1 : 5);
            end
        end

        repeat (3) @(negedge clk);
        check("model_drained", pend.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
